// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
//   Shares one external combinational 4-bit ALU between two requesters.
//   A round-robin arbiter grants one request at a time. The controller
//   latches the granted opcode and operands and drives the ALU. It then
//   captures the result and pulses the done line of the granted requester.
//   An unsigned 4x4 multiply is built from MUL_STEPS shift-add passes
//   through the ALU adder.
//
//   Bit order: every [0:N] vector uses bit 0 as the LSB.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   req0/op0/a0/b0        requester 0: level request, opcode, operands
//   req1/op1/a1/b1        requester 1: same meaning
//   done0, done1          one-cycle completion pulse to the granted requester
//   res[0:7], err         result and illegal-opcode flag, held until next capture
//   busy                  high whenever the controller is not idle
//   gnt_id                requester currently or last served
//   alu_a, alu_b          ALU operands
//   alu_c0, alu_c1        ALU function select (c1c0: 00 add, 01 and, 10 not-a, 11 xnor)
//   alu_y, alu_z          ALU results; z[3] is carry-out in add mode
module alu_share_ctrl #(
  parameter int MUL_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [0:3] a0,
  input  logic [0:3] b0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [0:3] a1,
  input  logic [0:3] b1,
  output logic       done0,
  output logic       done1,
  output logic [0:7] res,
  output logic       err,
  output logic       busy,
  output logic       gnt_id,
  output logic [0:3] alu_a,
  output logic [0:3] alu_b,
  output logic       alu_c0,
  output logic       alu_c1,
  input  logic [0:3] alu_y,
  input  logic [0:3] alu_z
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int STEP_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

  logic [1:0]        state;
  logic [STEP_W-1:0] step;
  logic [2:0]        op_q;
  logic [0:3]        a_q;
  logic [0:3]        b_q;
  logic [0:3]        acc;
  logic [0:3]        mq;

  logic              grant;
  logic              pick;
  logic [2:0]        sel_op;
  logic [0:3]        sel_a;
  logic [0:3]        sel_b;
  logic [0:3]        acc_next;
  logic [0:3]        mq_next;
  logic [0:7]        exec_res;
  logic              exec_err;

  // gnt_id doubles as the last-grant pointer: on a tie the other side wins.
  assign pick   = (req0 && req1) ? ~gnt_id : req1;
  assign grant  = (state == S_IDLE) && (req0 || req1);
  assign sel_op = pick ? op1 : op0;
  assign sel_a  = pick ? a1  : a0;
  assign sel_b  = pick ? b1  : b0;

  // One shift-add step: {carry, sum, mq} shifted one place toward the LSB.
  assign acc_next = {alu_y[1:3], alu_z[3]};
  assign mq_next  = {mq[1:3], alu_y[0]};

  assign busy  = (state != S_IDLE);
  assign done0 = (state == S_DONE) && !gnt_id;
  assign done1 = (state == S_DONE) &&  gnt_id;

  // ALU drive: zero unless executing a legal op or stepping the multiply.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_c0 = 1'b0;
    alu_c1 = 1'b0;
    case (state)
      S_EXEC: begin
        if (!op_q[2]) begin
          alu_a            = a_q;
          alu_b            = b_q;
          {alu_c1, alu_c0} = op_q[1:0];
        end
      end
      S_MUL: begin
        alu_a = acc;
        alu_b = mq[0] ? a_q : 4'b0000;
      end
      default: ;
    endcase
  end

  // Single-cycle result formatting from the ALU outputs.
  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
    case (op_q)
      3'b000:         exec_res = {alu_y, alu_z[3], 3'b000};
      3'b001, 3'b010: exec_res = {alu_y, 4'b0000};
      3'b011:         exec_res = {&alu_z, 7'b0000000};
      default:        exec_err = 1'b1;
    endcase
  end

  // Control state, arbitration pointer and captured result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      gnt_id <= 1'b1;
      step   <= '0;
      res    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            gnt_id <= pick;
            state  <= (sel_op == 3'b100) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          res   <= exec_res;
          err   <= exec_err;
          state <= S_DONE;
        end
        S_MUL: begin
          if (step == LAST_STEP) begin
            step  <= '0;
            res   <= {mq_next, acc_next};
            err   <= 1'b0;
            state <= S_DONE;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand and multiply datapath registers; qualified by state, so no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      op_q <= sel_op;
      a_q  <= sel_a;
      b_q  <= sel_b;
      acc  <= '0;
      mq   <= sel_b;
    end else if (state == S_MUL) begin
      acc <= acc_next;
      mq  <= mq_next;
    end
  end

endmodule
